rptr_aempty: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 27 ++
 rtl/sync_ptr.sv | 37 +++
 rtl/rptr_aempty.sv | 90 +++++++++
 tb/tb_rptr_aempty.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: binary <-> Gray conversion.
// The read-pointer and write-pointer blocks both import these.
package async_fifo_pkg;

    // Widest pointer these helpers handle. Callers zero-extend narrower
    // pointers into this width and truncate the result back down. Zero
    // extension leaves both conversions correct for any width up to this one.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Binary to reflected Gray code.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return (b >> 1) ^ b;
    endfunction

    // Reflected Gray code to binary: a running XOR that starts at the MSB.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ptr.sv
// Generic N-stage, W-bit pointer synchronizer with async active-high reset.
// It is only safe for Gray-coded inputs, where at most one bit changes at a time.
module sync_ptr #(
    parameter int W = 5,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [N];

    // Shift the asynchronous pointer through N flop stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these stages form a small array of flops, not a RAM.
            // Resetting them is cheap, and it makes rq_wptr deterministic
            // right after reset.
            for (int i = 0; i < N; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments give every stage the old value
            // of its neighbour. A blocking assignment here would collapse
            // the chain into a single flop.
            stage[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/rptr_aempty.sv
// Read-side pointer and flag generator for the dual-clock FIFO. It does the
// following in the rclk domain:
//   - synchronizes the Gray write pointer;
//   - advances the binary and Gray read pointers;
//   - registers the empty, almost-empty and occupancy outputs.
module rptr_aempty
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int AREMPTYSIZE = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rq_wptr;
    logic          rd_ok;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] aempty_bin;
    logic [PW-1:0] aempty_gray;
    logic [PW-1:0] level_next;
    logic          empty_next;
    logic          aempty_next;

    // The write pointer crosses into rclk here. It is Gray coded, so it can
    // be resynchronized bit by bit without ever producing a torn value.
    sync_ptr #(
        .W (PW),
        .N (SYNC_STAGES)
    ) u_sync_wptr (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr),
        .q   (rq_wptr)
    );

    // Reading an empty FIFO is ignored, so the pointers can never underflow.
    assign rd_ok = rinc & ~rempty;

    // Next-state pointers and flags.
    // Empty and almost-empty are both judged against the post-read pointer,
    // so rempty rises on the same edge that accepts the final read.
    always_comb begin
        // NOTE: each signal gets a value on every path through this block,
        // so no latch is inferred.
        rbinnext    = rbin + PW'(rd_ok);
        rgraynext   = PW'(bin2gray(PTR_MAX_W'(rbinnext)));
        aempty_bin  = rbinnext + PW'(AREMPTYSIZE);
        aempty_gray = PW'(bin2gray(PTR_MAX_W'(aempty_bin)));
        // Subtraction wraps modulo 2^PW. The extra MSB keeps the full case
        // (2^ADDRSIZE entries) distinct from the empty case.
        level_next  = PW'(gray2bin(PTR_MAX_W'(rq_wptr))) - rbinnext;
        empty_next  = (rgraynext == rq_wptr);
        // This is an equality test: high only when exactly AREMPTYSIZE
        // entries remain.
        aempty_next = (aempty_gray == rq_wptr);
    end

    // Register the pointers and the consumer-facing flags.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b0;
            rlevel  <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            rempty  <= empty_next;
            raempty <= aempty_next;
            rlevel  <= level_next;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_aempty.sv
// Self-checking bench for rptr_aempty.
// The reference model tracks total words written and read as plain integers.
// Visibility of a write is delayed by the synchronizer depth through a
// history queue. Occupancy is the difference between the visible write count
// and the read count.
module tb_rptr_aempty;

    localparam int ADDRSIZE    = 4;
    localparam int AREMPTYSIZE = 1;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 1 << ADDRSIZE;
    localparam int PTR_MOD     = 2 * DEPTH;

    logic                rclk = 1'b0;
    logic                rrst;
    logic                rinc;
    logic [ADDRSIZE:0]   wptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   rlevel;

    rptr_aempty #(
        .ADDRSIZE    (ADDRSIZE),
        .AREMPTYSIZE (AREMPTYSIZE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rinc    (rinc),
        .wptr    (wptr),
        .rempty  (rempty),
        .raempty (raempty),
        .raddr   (raddr),
        .rptr    (rptr),
        .rlevel  (rlevel)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int wcnt;
    int rcnt;
    int hist[$];
    bit m_empty;
    bit m_aempty;
    int m_level;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDRSIZE:0] gray_of(input int n);
        logic [ADDRSIZE:0] b;
        b = (ADDRSIZE+1)'(n % PTR_MOD);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wcnt = 0;
        rcnt = 0;
        hist = {};
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(0);
        m_empty  = 1'b1;
        m_aempty = 1'b0;
        m_level  = 0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".rempty"},  32'(rempty),  32'(m_empty));
        check({ph, ".raempty"}, 32'(raempty), 32'(m_aempty));
        check({ph, ".rlevel"},  32'(rlevel),  32'(m_level));
        check({ph, ".raddr"},   32'(raddr),   32'(rcnt % DEPTH));
        check({ph, ".rptr"},    32'(rptr),    32'(gray_of(rcnt)));
    endtask

    // One rclk cycle: drive the inputs, update the model at the edge, and
    // compare at the following falling edge.
    task automatic step(input string ph, input bit rd, input bit wr);
        int vis;
        if (wr) wcnt++;
        wptr = gray_of(wcnt);
        rinc = rd;
        @(posedge rclk);
        vis = hist.pop_front();
        hist.push_back(wcnt);
        if (rd && !m_empty) rcnt++;
        m_level  = vis - rcnt;
        m_empty  = (m_level == 0);
        m_aempty = (m_level == AREMPTYSIZE);
        @(negedge rclk);
        check_outputs(ph);
    endtask

    initial begin
        int aempty_hits;
        int saved_rcnt;

        // Power-on reset.
        rrst = 1'b1;
        rinc = 1'b0;
        wptr = '0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge rclk);
        rrst = 1'b0;

        // First write: visible three edges later, then drained by one read.
        step("first_wr", 1'b0, 1'b1);
        step("first_wr", 1'b0, 1'b0);
        check("first_wr_still_empty", 32'(rempty), 32'd1);
        step("first_wr", 1'b0, 1'b0);
        check("first_wr_level", 32'(rlevel), 32'd1);
        check("first_wr_aempty", 32'(raempty), 32'd1);
        step("first_rd", 1'b1, 1'b0);
        check("first_rd_raddr", 32'(raddr), 32'd1);
        check("first_rd_empty", 32'(rempty), 32'd1);

        // Fill to 16 entries in one pointer jump, then drain.
        wcnt = wcnt + DEPTH - 1;
        step("fill", 1'b0, 1'b1);
        step("fill", 1'b0, 1'b0);
        step("fill", 1'b0, 1'b0);
        check("fill_level_full", 32'(rlevel), 32'(DEPTH));
        aempty_hits = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b1, 1'b0);
            if (raempty) aempty_hits++;
        end
        check("drain_aempty_once", 32'(aempty_hits), 32'd1);
        check("drain_empty", 32'(rempty), 32'd1);

        // Reads while empty are ignored.
        saved_rcnt = rcnt;
        for (int i = 0; i < 4; i++) step("underflow", 1'b1, 1'b0);
        check("underflow_rptr", 32'(rptr), 32'(gray_of(saved_rcnt)));
        check("underflow_level", 32'(rlevel), 32'd0);

        // Single write/read pairs carry the pointers through wrap-around.
        for (int i = 0; i < 40; i++) begin
            step("wrap", 1'b0, 1'b1);
            step("wrap", 1'b0, 1'b0);
            step("wrap", 1'b0, 1'b0);
            step("wrap", 1'b1, 1'b0);
        end

        // Read accept and synchronized write arrival on the same edge.
        step("conc", 1'b0, 1'b1);
        step("conc", 1'b0, 1'b1);
        step("conc", 1'b0, 1'b0);
        step("conc", 1'b0, 1'b0);
        check("conc_pre_level", 32'(rlevel), 32'd2);
        step("conc", 1'b0, 1'b1);
        step("conc", 1'b0, 1'b0);
        step("conc", 1'b1, 1'b0);
        check("conc_level", 32'(rlevel), 32'd2);
        check("conc_empty", 32'(rempty), 32'd0);
        check("conc_aempty", 32'(raempty), 32'd0);

        // Random read/write stepping; writes never overrun the FIFO depth.
        for (int i = 0; i < 3000; i++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom % 2);
            wr = ($urandom % 2 == 1) && (wcnt - rcnt < DEPTH);
            step("rand", rd, wr);
        end

        // Asynchronous reset mid-stream with five entries visible.
        @(negedge rclk);
        rrst = 1'b1;
        model_reset();
        wptr = '0;
        @(negedge rclk);
        rrst = 1'b0;
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b0, 1'b1);
        step("pre_rst", 1'b0, 1'b0);
        step("pre_rst", 1'b0, 1'b0);
        check("pre_rst_level", 32'(rlevel), 32'd5);
        #2;
        rrst = 1'b1;
        model_reset();
        wptr = '0;
        #1;
        check_outputs("mid_rst");
        check("mid_rst_level", 32'(rlevel), 32'd0);
        @(negedge rclk);
        rrst = 1'b0;
        step("post_rst", 1'b0, 1'b1);
        step("post_rst", 1'b0, 1'b0);
        step("post_rst", 1'b0, 1'b0);
        step("post_rst", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
